// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: issue, writeback and flush signals between the
// decode stage (master) and the register-file scoreboard (slave), plus the
// scoreboard's status outputs.
interface regfile_scoreboard_if;
  // decode -> scoreboard
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_writes;
  logic [4:0]  src1;
  logic        src1_used;
  logic [4:0]  src2;
  logic        src2_used;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  // scoreboard -> decode
  logic        issue_ready;
  logic        stall;
  logic [31:0] busy_mask;
  logic [6:0]  outstanding;
  logic        wb_err;
  logic [15:0] stall_cycles;

  modport master (
    output issue_valid, issue_rd, issue_writes,
    output src1, src1_used, src2, src2_used,
    output wb_valid, wb_rd, flush,
    input  issue_ready, stall, busy_mask, outstanding, wb_err, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rd, issue_writes,
    input  src1, src1_used, src2, src2_used,
    input  wb_valid, wb_rd, flush,
    output issue_ready, stall, busy_mask, outstanding, wb_err, stall_cycles
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: tracks in-flight register writes with one small
// counter per architectural register and holds issue while a source is
// pending or a destination counter is full. A flush moves the block into
// DRAIN, where nothing issues until every outstanding write has retired.
// The register at ZERO_REG reads as zero and is never tracked.
//
// Optional feature: define SCOREBOARD_STALL_CNT_EN to build a saturating
// 16-bit count of stalled issue cycles; otherwise stall_cycles is tied to 0.
module regfile_scoreboard #(
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [4:0]       ZR      = 5'(ZERO_REG);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];

  logic [31:0] busy_reg, busy_next;
  logic [6:0]  outstanding_reg, outstanding_next;
  logic        wb_err_reg, wb_err_next;

  logic src1_hit, src2_hit, rd_full, hazard;
  logic issue_ready, accept;
  logic wr_hit, wb_hit, wb_zero;

  // Hazards look only at registered counters: a writeback landing this
  // cycle does not release a dependent instruction until the next cycle.
  assign src1_hit = sb.src1_used & (sb.src1 != ZR) & (cnt_reg[sb.src1] != '0);
  assign src2_hit = sb.src2_used & (sb.src2 != ZR) & (cnt_reg[sb.src2] != '0);
  assign rd_full  = sb.issue_writes & (sb.issue_rd != ZR) &
                    (cnt_reg[sb.issue_rd] == CNT_MAX);
  assign hazard   = src1_hit | src2_hit | rd_full;

  assign issue_ready = (state_reg == RUN) & ~sb.flush & ~hazard;
  assign accept      = sb.issue_valid & issue_ready;

  assign wr_hit  = accept & sb.issue_writes & (sb.issue_rd != ZR);
  assign wb_hit  = sb.wb_valid & (sb.wb_rd != ZR);
  assign wb_zero = wb_hit & (cnt_reg[sb.wb_rd] == '0);

  // Per-register counter update: increment on an accepted write, decrement
  // on a retiring writeback, both together cancel out.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign cnt_next[gi]  = '0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_track
        logic inc, dec;
        assign inc = wr_hit & (sb.issue_rd == 5'(gi));
        assign dec = wb_hit & (sb.wb_rd == 5'(gi)) & (cnt_reg[gi] != '0);
        assign cnt_next[gi] = (inc && !dec) ? cnt_reg[gi] + 1'b1 :
                              (dec && !inc) ? cnt_reg[gi] - 1'b1 :
                                              cnt_reg[gi];
        assign busy_next[gi] = (cnt_next[gi] != '0);
      end
    end
  endgenerate

  // Total in-flight writes, registered alongside the counters.
  always_comb begin
    outstanding_next = '0;
    for (int i = 0; i < 32; i++) begin
      outstanding_next = outstanding_next + 7'(cnt_next[i]);
    end
  end

  // A writeback with nothing to retire is a protocol error; keep it sticky.
  assign wb_err_next = wb_err_reg | wb_zero;

  // Next state: a flush always lands in DRAIN; leave only once empty.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (sb.flush) state_next = DRAIN;
      end
      DRAIN: begin
        if (!sb.flush && (outstanding_reg == '0)) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // State, counters and registered status views.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      busy_reg        <= '0;
      outstanding_reg <= '0;
      wb_err_reg      <= 1'b0;
      for (int i = 0; i < 32; i++) cnt_reg[i] <= '0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= busy_next;
      outstanding_reg <= outstanding_next;
      wb_err_reg      <= wb_err_next;
      for (int i = 0; i < 32; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  assign sb.issue_ready = issue_ready;
  assign sb.stall       = sb.issue_valid & ~issue_ready;
  assign sb.busy_mask   = busy_reg;
  assign sb.outstanding = outstanding_reg;
  assign sb.wb_err      = wb_err_reg;

`ifdef SCOREBOARD_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Count stalled issue cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (sb.stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign sb.stall_cycles = stall_cnt_reg;
`else
  assign sb.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table-driven check of the register scoreboard.
// Each vector carries its inputs, the expected same-cycle issue_ready and
// the expected registered status after the clock edge. The post-edge
// expectations go through a queue: pushed when a vector is driven, popped
// and compared once the edge has produced the DUT's registered outputs.
module tb_regfile_scoreboard;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic        wr;
    logic [4:0]  s1;
    logic        u1;
    logic [4:0]  s2;
    logic        u2;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        e_ready;
    logic [31:0] e_busy;
    logic [6:0]  e_out;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [6:0]  out;
    logic        err;
  } post_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  post_t sb_q[$];
  vec_t tbl [26];
  vec_t flush_seq [8];

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rd, input logic wr,
    input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
    input logic wbv, input logic [4:0] wbrd, input logic fl,
    input logic er, input logic [31:0] eb, input logic [6:0] eo, input logic ee);
    vec_t v;
    v.iv = iv; v.rd = rd; v.wr = wr; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.e_ready = er; v.e_busy = eb; v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_writes = 1'b0;
    bus.src1 = '0; bus.src1_used = 1'b0; bus.src2 = '0; bus.src2_used = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    post_t p;
    @(negedge clk);
    bus.issue_valid = v.iv; bus.issue_rd = v.rd; bus.issue_writes = v.wr;
    bus.src1 = v.s1; bus.src1_used = v.u1; bus.src2 = v.s2; bus.src2_used = v.u2;
    bus.wb_valid = v.wbv; bus.wb_rd = v.wbrd; bus.flush = v.fl;
    #1;
    chk({tag, " issue_ready"}, 32'(bus.issue_ready), 32'(v.e_ready));
    chk({tag, " stall"}, 32'(bus.stall), 32'(v.iv & ~v.e_ready));
    p.busy = v.e_busy; p.out = v.e_out; p.err = v.e_err;
    sb_q.push_back(p);
    @(posedge clk);
    #1;
    p = sb_q.pop_front();
    chk({tag, " busy_mask"}, bus.busy_mask, p.busy);
    chk({tag, " outstanding"}, 32'(bus.outstanding), 32'(p.out));
    chk({tag, " wb_err"}, 32'(bus.wb_err), 32'(p.err));
    $display("%s: iv=%0b rd=%0d wr=%0b s1=%0d/%0b s2=%0d/%0b wb=%0b/%0d fl=%0b -> ready=%0b busy=%h out=%0d err=%0b",
             tag, v.iv, v.rd, v.wr, v.s1, v.u1, v.s2, v.u2, v.wbv, v.wbrd, v.fl,
             bus.issue_ready, bus.busy_mask, bus.outstanding, bus.wb_err);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge sees it.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst busy_mask"}, bus.busy_mask, 32'h0);
    chk({tag, " rst outstanding"}, 32'(bus.outstanding), 32'h0);
    chk({tag, " rst wb_err"}, 32'(bus.wb_err), 32'h0);
    chk({tag, " rst stall_cycles"}, 32'(bus.stall_cycles), 32'h0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    $display("%s: reset applied and released", tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_stall;
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("por busy_mask", bus.busy_mask, 32'h0);
    chk("por outstanding", 32'(bus.outstanding), 32'h0);
    chk("por wb_err", 32'(bus.wb_err), 32'h0);
    chk("por stall_cycles", 32'(bus.stall_cycles), 32'h0);
    chk("por issue_ready", 32'(bus.issue_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    //             iv rd wr s1 u1 s2 u2 wbv wbrd fl   rdy busy          out err
    tbl[0]  = mk(1, 3, 1, 1, 1, 2, 1, 0, 0, 0,  1, 32'h0000_0008, 1, 0); // ADD X3
    tbl[1]  = mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 0,  0, 32'h0000_0008, 1, 0); // SUB uses X3
    tbl[2]  = mk(1, 4, 1, 3, 1, 0, 0, 1, 3, 0,  0, 32'h0000_0000, 0, 0); // wb X3, no bypass
    tbl[3]  = mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 0,  1, 32'h0000_0010, 1, 0); // SUB issues
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  1, 32'h0000_0000, 0, 0);
    tbl[5]  = mk(1,31, 1,31, 1,31, 1, 0, 0, 0,  1, 32'h0000_0000, 0, 0); // XZR
    tbl[6]  = mk(1,31, 1,31, 1,31, 1, 0, 0, 0,  1, 32'h0000_0000, 0, 0);
    tbl[7]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0020, 1, 0); // X5 #1
    tbl[8]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0020, 2, 0); // X5 #2
    tbl[9]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0020, 3, 0); // X5 #3
    tbl[10] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0020, 3, 0); // counter full
    tbl[11] = mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  0, 32'h0000_0020, 2, 0); // wb X5
    tbl[12] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0020, 3, 0); // X5 #4 accepted
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 32'h0000_0020, 2, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 32'h0000_0020, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 32'h0000_0000, 0, 0);
    tbl[16] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0040, 1, 0);
    tbl[17] = mk(1, 6, 1, 0, 0, 0, 0, 1, 6, 0,  1, 32'h0000_0040, 1, 0); // issue+wb same reg
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  1, 32'h0000_0000, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 32'h0000_0000, 0, 1); // wb with zero count
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0000, 0, 1); // sticky
    tbl[21] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0100, 1, 1);
    tbl[22] = mk(1, 9, 1, 0, 0, 8, 1, 0, 0, 0,  0, 32'h0000_0100, 1, 1); // src2 hazard
    tbl[23] = mk(1, 9, 1, 0, 0, 8, 1, 1, 8, 0,  0, 32'h0000_0000, 0, 1);
    tbl[24] = mk(1, 9, 1, 0, 0, 8, 1, 0, 0, 0,  1, 32'h0000_0200, 1, 1);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  1, 32'h0000_0000, 0, 1);

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Flush and drain: two writes in flight, nothing issues until both
    // retire, then one more DRAIN cycle before RUN.
    do_reset("pre-flush");
    flush_seq[0] = mk(1,10, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0400, 1, 0);
    flush_seq[1] = mk(1,11, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0C00, 2, 0);
    flush_seq[2] = mk(1,12, 1, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0000_0C00, 2, 0); // flush
    flush_seq[3] = mk(1,12, 1, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0000_0C00, 2, 0); // flush in DRAIN
    flush_seq[4] = mk(1,12, 1, 0, 0, 0, 0, 1,10, 0,  0, 32'h0000_0800, 1, 0);
    flush_seq[5] = mk(1,12, 1, 0, 0, 0, 0, 1,11, 0,  0, 32'h0000_0000, 0, 0);
    flush_seq[6] = mk(1,12, 1, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0000, 0, 0); // leaving DRAIN
    flush_seq[7] = mk(1,12, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_1000, 1, 0); // RUN again
    for (int i = 0; i < 8; i++) begin
      apply(flush_seq[i], $sformatf("flush%0d", i));
    end

    // Error, then reset in the middle of DRAIN.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 32'h0000_1000, 1, 1), "err-wb7");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0000_1000, 1, 1), "err-flush");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_1000, 1, 1), "err-drain");
    do_reset("mid-drain");
    apply(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0008, 1, 0), "post-rst");

    // Ten cycles of a held source hazard.
    do_reset("pre-stall");
    apply(mk(1,20, 1, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0010_0000, 1, 0), "stall-prod");
    for (int i = 0; i < 10; i++) begin
      apply(mk(1,21, 1,20, 1, 0, 0, 0, 0, 0,  0, 32'h0010_0000, 1, 0), $sformatf("stall%0d", i));
    end
`ifdef SCOREBOARD_STALL_CNT_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif
    chk("stall_cycles after hazard", 32'(bus.stall_cycles), 32'(exp_stall));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1,20, 0,  1, 32'h0000_0000, 0, 0), "stall-wb");
    chk("stall_cycles held", 32'(bus.stall_cycles), 32'(exp_stall));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter: CNT_W, 2, width of per-register in-flight write counter (max outstanding writes per register = 2^CNT_W-1).
REQ-002 Parameter: ZERO_REG, 31, register index hardwired to zero (XZR); never tracked.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: issue_valid  input  1  decode presents an instruction for issue.
REQ-006 Port: issue_rd  input  5  destination register (Instruction[4:0]).
REQ-007 Port: issue_writes  input  1  instruction writes issue_rd (RegWrite).
REQ-008 Port: src1 / src1_used  input  5 / 1  first source (Instruction[9:5]) and its valid flag.
REQ-009 Port: src2 / src2_used  input  5 / 1  second source (Rm or Rt per Reg2Loc) and its valid flag.
REQ-010 Port: wb_valid / wb_rd  input  1 / 5  register-file write completing this cycle.
REQ-011 Port: flush  input  1  branch taken (PCSrc); squash issue and drain.
REQ-012 Port: issue_ready  output  1  issue accepted this cycle when issue_valid is high.
REQ-013 Port: stall  output  1  issue_valid & ~issue_ready.
REQ-014 Port: busy_mask  output  32  bit i set when counter i nonzero.
REQ-015 Port: outstanding  output  7  sum of all counters.
REQ-016 Port: wb_err  output  1  sticky: writeback to a register with zero count.
REQ-017 Port: stall_cycles  output  16  saturating stall counter (see Configuration).

Function
REQ-018 FSM states: RUN, DRAIN; RUN -> DRAIN when flush=1; DRAIN -> RUN when outstanding=0 and flush=0; flush in DRAIN holds DRAIN.
REQ-019 Hazard, from registered counters only (no same-cycle writeback bypass): (src1_used & src1!=ZERO_REG & cnt[src1]!=0) | (src2_used & src2!=ZERO_REG & cnt[src2]!=0) | (issue_writes & issue_rd!=ZERO_REG & cnt[issue_rd]==max).
REQ-020 issue_ready = (state==RUN) & ~flush & ~hazard; combinational, zero-cycle latency.
REQ-021 Accepted issue with issue_writes=1 and issue_rd!=ZERO_REG increments cnt[issue_rd] at the next edge.
REQ-022 wb_valid with wb_rd!=ZERO_REG and cnt[wb_rd]!=0 decrements cnt[wb_rd] at the next edge.
REQ-023 wb_valid with wb_rd!=ZERO_REG and cnt[wb_rd]==0 leaves counter at 0 and sets wb_err until reset.
REQ-024 Simultaneous accepted issue and writeback to the same register leave its counter unchanged.
REQ-025 Writebacks retire normally in DRAIN and during flush; flush does not clear counters.
REQ-026 ZERO_REG counter permanently 0; busy_mask[ZERO_REG]=0; ZERO_REG as source never stalls.
REQ-027 outstanding and busy_mask are registered views updated with counters, never wrapping.

Reset
REQ-028 rst_n low asynchronously forces state=RUN, all counters 0, busy_mask=0, outstanding=0, wb_err=0, stall_cycles=0.
REQ-029 Reset asserted mid-operation discards all in-flight tracking; issue_ready=1 on the first edge after release when no flush.

Configuration
REQ-030 Macro SCOREBOARD_STALL_CNT_EN defined: stall_cycles increments each cycle stall=1, saturates at 16'hFFFF.
REQ-031 Macro SCOREBOARD_STALL_CNT_EN undefined: stall_cycles tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-032 Issue ADD X3 (writes), then SUB with src1=X3 next cycle, no wb -> stall=1, busy_mask=32'h8; wb_rd=3 -> issue_ready=1 one cycle after wb.
REQ-033 Three issues writing X5, fourth issue writing X5 -> fourth stalled (cnt=3, CNT_W=2); one wb_rd=5 -> accepted next cycle, outstanding=3.
REQ-034 Issue writing X31 and src1=X31 -> never stalls, outstanding stays 0, busy_mask=0.
REQ-035 Two writes outstanding, flush pulse -> DRAIN, issue_ready=0 until both wbs retire, RUN the cycle after outstanding=0.
REQ-036 wb_valid wb_rd=7 with cnt[7]=0 -> wb_err=1 and stays 1; rst_n low mid-DRAIN -> all outputs 0, RUN, wb_err=0.
REQ-037 With SCOREBOARD_STALL_CNT_EN, hold hazard 10 cycles -> stall_cycles=10; without macro -> stall_cycles=0.
